spi_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SPI master transceiver among NUM_REQ on-chip requesters, such as the inertial sensor interface, the A2D interface and the config block. It grants one requester at a time and drives that requester's 16-bit command into the master with a one-cycle write strobe. It waits for the master's done, then returns the read data with a per-requester done pulse. A watchdog recovers the bus if the master never completes.

---
 rtl/spi_req_arbiter_pkg.sv | 38 +++
 rtl/spi_req_arbiter_if.sv | 42 ++++
 rtl/spi_req_arbiter_rr_pick_onehot.sv | 30 +++
 rtl/spi_req_arbiter.sv | 119 +++++++++++
 tb/tb_spi_req_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and helpers for the SPI request arbiter.
//   arb_state_t : arbiter sequencing states
//   CMD_W       : width of one SPI command / read word
//   MAX_REQ     : widest requester vector rr_pick handles
//   rr_pick     : round-robin first-set-bit search returning a one-hot grant
package spi_arb_pkg;

    localparam int CMD_W   = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CMPL  = 3'd3,
        ABORT = 3'd4
    } arb_state_t;

    // Searches ptr, ptr+1, ... wrapping modulo n; returns the first set
    // request as a one-hot vector, or zero when nothing in [n-1:0] is set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n = MAX_REQ
    );
        logic [MAX_REQ-1:0] g;
        logic [2:0]         idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && g == '0 && req[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesters / SPI master and the arbiter.
//   req, req_cmd        : requester level requests and flattened commands
//   req_done, req_err   : one-cycle completion / abort pulses, one-hot
//   rd_data             : last completed read word
//   grant, busy         : current owner (one-hot) and activity flag
//   spi_wrt, spi_cmd    : one-cycle write strobe and command to the master
//   spi_done, spi_rd_data : master done level and read data
//
// Handshake: a requester raises req[i] with req_cmd slice i stable and keeps
// both unchanged until it sees req_done[i] or req_err[i]; it may then drop
// req[i] on the following cycle. Toward the master, spi_wrt is a single-cycle
// strobe with spi_cmd stable, and completion is the rising edge of spi_done.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import spi_arb_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [CMD_W*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]       req_done;
    logic [NUM_REQ-1:0]       req_err;
    logic [CMD_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     spi_wrt;
    logic [CMD_W-1:0]         spi_cmd;
    logic                     spi_done;
    logic [CMD_W-1:0]         spi_rd_data;

    // Arbiter side.
    modport slave (
        input  req, req_cmd, spi_done, spi_rd_data,
        output req_done, req_err, rd_data, grant, busy, spi_wrt, spi_cmd
    );

    // Requesters plus SPI master side.
    modport master (
        output req, req_cmd, spi_done, spi_rd_data,
        input  req_done, req_err, rd_data, grant, busy, spi_wrt, spi_cmd
    );

endinterface

// File: rtl/spi_req_arbiter_rr_pick_onehot.sv
// Combinational round-robin priority picker.
//   req    : request vector
//   ptr    : index of the highest-priority requester (must be < N)
//   onehot : first set request at or after ptr, wrapping
//   any    : at least one request is set
module rr_pick_onehot
    import spi_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] onehot,
    output logic         any
);

    logic [MAX_REQ-1:0] req_w;
    logic [MAX_REQ-1:0] pick_w;

    always_comb begin
        req_w        = '0;
        req_w[N-1:0] = req;
    end

    assign pick_w = rr_pick(req_w, ptr, N);
    assign onehot = pick_w[N-1:0];
    // Nonzero exactly when some request in range is set.
    assign any    = |pick_w;

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : requester and SPI master signals (slave modport)
//   state_dbg  : current sequencer state
// A granted command is strobed into the master for one cycle, completion is
// the rising edge of spi_done, and a watchdog aborts after TMO_CYC cycles.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TMO_CYC = 4095,
    parameter int TMO_W   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_req_arbiter_if.slave    bus,
    output arb_state_t          state_dbg
);

    arb_state_t         state;
    logic [2:0]         rr_ptr;
    logic [2:0]         grant_idx;
    logic [2:0]         pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [CMD_W-1:0]   pick_cmd;
    logic [TMO_W-1:0]   watchdog;
    logic [TMO_W-1:0]   wd_next;
    logic               spi_done_q;
    logic               done_rise;
    logic [2:0]         ptr_next;

    rr_pick_onehot #(.N(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        pick_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = 3'(i);
                pick_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    // A done level left over from the previous transfer must not complete
    // the current one, so only the edge counts.
    assign done_rise = bus.spi_done & ~spi_done_q;
    assign wd_next   = watchdog + TMO_W'(1);
    assign ptr_next  = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            watchdog     <= '0;
            spi_done_q   <= 1'b0;
            bus.grant    <= '0;
            bus.req_done <= '0;
            bus.req_err  <= '0;
            bus.rd_data  <= '0;
            bus.spi_wrt  <= 1'b0;
            bus.spi_cmd  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            spi_done_q   <= bus.spi_done;
            bus.spi_wrt  <= 1'b0;
            bus.req_done <= '0;
            bus.req_err  <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        bus.grant   <= pick_oh;
                        grant_idx   <= pick_idx;
                        bus.spi_cmd <= pick_cmd;
                        // Strobe is high for the whole ISSUE cycle.
                        bus.spi_wrt <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= wd_next;
                    if (done_rise) begin
                        bus.rd_data  <= bus.spi_rd_data;
                        bus.req_done <= bus.grant;
                        state        <= CMPL;
                    end else if (wd_next == TMO_W'(TMO_CYC)) begin
                        bus.req_err <= bus.grant;
                        bus.busy    <= 1'b0;
                        state       <= ABORT;
                    end
                end
                CMPL, ABORT: begin
                    // Owner drops to lowest priority for the next search.
                    rr_ptr    <= ptr_next;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
module tb_spi_req_arbiter;
    import spi_arb_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 4095;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.NUM_REQ(N)) bus ();
    arb_state_t state_dbg;

    spi_req_arbiter #(.NUM_REQ(N), .TMO_CYC(TMO), .TMO_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Expected grant order for the round-robin scenario.
    logic [N-1:0] exp_q[$];

    // ---------------- SPI master model ----------------
    // Raises done model_lat cycles after the strobe; a stale done level is
    // cleared model_clr_dly cycles after the strobe (0 = at the strobe).
    int          model_lat     = 20;
    int          model_clr_dly = 0;
    bit          model_hang    = 1'b0;
    bit          model_fix_en  = 1'b0;
    logic [15:0] model_fix     = 16'h0;
    logic [15:0] cur_cmd;
    int          m_cnt;
    int          m_clr;
    bit          m_active;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spi_done    = 1'b0;
            bus.spi_rd_data = 16'h0;
            m_active        = 1'b0;
            m_clr           = 0;
            m_cnt           = 0;
        end else if (bus.spi_wrt) begin
            m_active = 1'b1;
            m_cnt    = model_lat;
            m_clr    = model_clr_dly;
            cur_cmd  = bus.spi_cmd;
            if (m_clr == 0) bus.spi_done = 1'b0;
        end else begin
            if (m_clr > 0) begin
                m_clr = m_clr - 1;
                if (m_clr == 0) bus.spi_done = 1'b0;
            end
            if (m_active && !model_hang) begin
                if (m_cnt <= 1) begin
                    bus.spi_done    = 1'b1;
                    bus.spi_rd_data = model_fix_en ? model_fix : (cur_cmd ^ 16'h5A5A);
                    m_active        = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bus.req     = '0;
        bus.req_cmd = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_wrt(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.spi_wrt) ok = 1'b1;
        end
    endtask

    task automatic wait_resp(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if ((bus.req_done | bus.req_err) != '0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req     = '0;
        bus.req_cmd = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.spi_wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b want 0", bus.spi_wrt); end
        checks++; if (bus.spi_cmd !== 16'h0) begin errors++; $display("FAIL reset_cmd: got %h want 0000", bus.spi_cmd); end
        checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); end
        checks++; if ((bus.req_done | bus.req_err) !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b/%b want 000/000", bus.req_done, bus.req_err); end
        checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        apply_reset();
        model_fix_en  = 1'b1;
        model_fix     = 16'h1234;
        model_lat     = 1100;
        model_clr_dly = 0;
        bus.req_cmd[31:16] = 16'hA5C3;
        bus.req            = 3'b010;
        // Decision on the first edge, strobe held through ISSUE and taken by
        // the master on the second edge.
        wait_wrt(4, cyc, ok);
        checks++; if (!ok || cyc != 1) begin errors++; $display("FAIL single_wrt_latency: got %0d want 1 (ok=%0b)", cyc, ok); end
        checks++; if (bus.grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", bus.grant); end
        checks++; if (bus.spi_cmd !== 16'hA5C3) begin errors++; $display("FAIL single_cmd: got %h want a5c3", bus.spi_cmd); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.spi_wrt !== 1'b0) begin errors++; $display("FAIL single_wrt_width: got %b want 0", bus.spi_wrt); end
        // done rises 1100 cycles after the strobe, req_done one cycle later.
        wait_resp(1200, cyc, ok);
        checks++; if (!ok || cyc != 1100) begin errors++; $display("FAIL single_done_time: got %0d want 1100 (ok=%0b)", cyc, ok); end
        checks++; if (bus.req_done !== 3'b010) begin errors++; $display("FAIL single_done: got %b want 010", bus.req_done); end
        checks++; if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL single_rd_data: got %h want 1234", bus.rd_data); end
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL single_done_pulse: got %b want 000", bus.req_done); end
        checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_release: got grant %b busy %b want 000 0", bus.grant, bus.busy); end
        checks++; if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL single_rd_hold: got %h want 1234", bus.rd_data); end
        model_fix_en = 1'b0;
    endtask

    task automatic test_round_robin();
        int           cyc;
        bit           ok;
        logic [N-1:0] exp_g;
        logic [15:0]  exp_c;
        logic [15:0]  cmd_tab [N];
        apply_reset();
        model_lat  = 20;
        cmd_tab[0] = 16'h1111;
        cmd_tab[1] = 16'h2222;
        cmd_tab[2] = 16'h3333;
        bus.req_cmd = {cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        bus.req = 3'b111;
        while (exp_q.size() > 0) begin
            exp_g = exp_q.pop_front();
            exp_c = 16'h0;
            for (int i = 0; i < N; i++) if (exp_g[i]) exp_c = cmd_tab[i];
            wait_wrt(8, cyc, ok);
            checks++; if (!ok || bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant: got %b want %b (ok=%0b)", bus.grant, exp_g, ok); end
            checks++; if (bus.spi_cmd !== exp_c) begin errors++; $display("FAIL rr_cmd: got %h want %h", bus.spi_cmd, exp_c); end
            wait_resp(40, cyc, ok);
            checks++; if (!ok || bus.req_done !== exp_g) begin errors++; $display("FAIL rr_done: got %b want %b (ok=%0b)", bus.req_done, exp_g, ok); end
            checks++; if (bus.rd_data !== (exp_c ^ 16'h5A5A)) begin errors++; $display("FAIL rr_rd_data: got %h want %h", bus.rd_data, exp_c ^ 16'h5A5A); end
            bus.req = bus.req & ~exp_g;
            @(negedge clk);
            bus.req = 3'b111;
        end
        bus.req = 3'b000;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_fairness();
        int cyc;
        bit ok;
        apply_reset();
        model_lat   = 40;
        bus.req_cmd = {16'h3333, 16'h2222, 16'h1111};
        bus.req     = 3'b001;
        wait_wrt(4, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b001) begin errors++; $display("FAIL fair_first_grant: got %b want 001 (ok=%0b)", bus.grant, ok); end
        repeat (10) @(negedge clk);
        bus.req[2] = 1'b1;
        wait_resp(60, cyc, ok);
        checks++; if (!ok || bus.req_done !== 3'b001) begin errors++; $display("FAIL fair_first_done: got %b want 001 (ok=%0b)", bus.req_done, ok); end
        // req0 stays high, but requester 2 must be served first.
        wait_wrt(8, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b100) begin errors++; $display("FAIL fair_second_grant: got %b want 100 (ok=%0b)", bus.grant, ok); end
        checks++; if (bus.spi_cmd !== 16'h3333) begin errors++; $display("FAIL fair_second_cmd: got %h want 3333", bus.spi_cmd); end
        wait_resp(60, cyc, ok);
        checks++; if (!ok || bus.req_done !== 3'b100) begin errors++; $display("FAIL fair_second_done: got %b want 100 (ok=%0b)", bus.req_done, ok); end
        bus.req = 3'b001;
        wait_wrt(8, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b001) begin errors++; $display("FAIL fair_third_grant: got %b want 001 (ok=%0b)", bus.grant, ok); end
        wait_resp(60, cyc, ok);
        bus.req = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stale_done();
        int cyc;
        bit ok;
        apply_reset();
        model_lat     = 20;
        model_clr_dly = 0;
        bus.req_cmd   = {16'h3333, 16'h2222, 16'h1111};
        bus.req       = 3'b001;
        wait_wrt(4, cyc, ok);
        wait_resp(40, cyc, ok);
        checks++; if (!ok || bus.req_done !== 3'b001) begin errors++; $display("FAIL stale_setup_done: got %b want 001 (ok=%0b)", bus.req_done, ok); end
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
        // done is still high; the master lowers it 6 cycles after the strobe
        // and raises it again 30 cycles after the strobe.
        model_clr_dly = 6;
        model_lat     = 30;
        bus.req       = 3'b010;
        wait_wrt(4, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b010) begin errors++; $display("FAIL stale_grant: got %b want 010 (ok=%0b)", bus.grant, ok); end
        wait_resp(60, cyc, ok);
        checks++; if (!ok || cyc != 31) begin errors++; $display("FAIL stale_done_time: got %0d want 31 (ok=%0b)", cyc, ok); end
        checks++; if (bus.req_done !== 3'b010) begin errors++; $display("FAIL stale_done: got %b want 010", bus.req_done); end
        checks++; if (bus.rd_data !== 16'h7878) begin errors++; $display("FAIL stale_rd_data: got %h want 7878", bus.rd_data); end
        bus.req       = 3'b000;
        model_clr_dly = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_watchdog();
        int cyc;
        bit ok;
        apply_reset();
        model_lat   = 20;
        model_hang  = 1'b0;
        bus.req_cmd = {16'hCAFE, 16'hBEEF, 16'h0F0F};
        bus.req     = 3'b001;
        wait_wrt(4, cyc, ok);
        wait_resp(40, cyc, ok);
        checks++; if (!ok || bus.rd_data !== 16'h5555) begin errors++; $display("FAIL wd_setup_rd: got %h want 5555 (ok=%0b)", bus.rd_data, ok); end
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        model_hang = 1'b1;
        bus.req    = 3'b110;
        wait_wrt(4, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b010) begin errors++; $display("FAIL wd_grant: got %b want 010 (ok=%0b)", bus.grant, ok); end
        // WAIT starts one edge after the strobe cycle and lasts TMO cycles.
        wait_resp(TMO + 100, cyc, ok);
        checks++; if (!ok || cyc != TMO + 1) begin errors++; $display("FAIL wd_err_time: got %0d want %0d (ok=%0b)", cyc, TMO + 1, ok); end
        checks++; if (bus.req_err !== 3'b010) begin errors++; $display("FAIL wd_err: got %b want 010", bus.req_err); end
        checks++; if (bus.req_done !== 3'b000) begin errors++; $display("FAIL wd_no_done: got %b want 000", bus.req_done); end
        checks++; if (bus.rd_data !== 16'h5555) begin errors++; $display("FAIL wd_rd_hold: got %h want 5555", bus.rd_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wd_busy: got %b want 0", bus.busy); end
        bus.req    = 3'b100;
        model_hang = 1'b0;
        wait_wrt(8, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b100) begin errors++; $display("FAIL wd_next_grant: got %b want 100 (ok=%0b)", bus.grant, ok); end
        checks++; if (bus.spi_cmd !== 16'hCAFE) begin errors++; $display("FAIL wd_next_cmd: got %h want cafe", bus.spi_cmd); end
        wait_resp(40, cyc, ok);
        checks++; if (!ok || bus.req_done !== 3'b100) begin errors++; $display("FAIL wd_next_done: got %b want 100 (ok=%0b)", bus.req_done, ok); end
        checks++; if (bus.rd_data !== 16'h90A4) begin errors++; $display("FAIL wd_next_rd: got %h want 90a4", bus.rd_data); end
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        apply_reset();
        model_lat   = 50;
        bus.req_cmd = {16'h3333, 16'h2222, 16'h4444};
        bus.req     = 3'b001;
        wait_wrt(4, cyc, ok);
        repeat (10) @(negedge clk);
        checks++; if (state_dbg !== WAIT) begin errors++; $display("FAIL rstmid_in_wait: got %0d want %0d", state_dbg, WAIT); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.spi_wrt !== 1'b0) begin errors++; $display("FAIL rstmid_async: got grant %b busy %b wrt %b want 000 0 0", bus.grant, bus.busy, bus.spi_wrt); end
        checks++; if (state_dbg !== IDLE || bus.spi_cmd !== 16'h0) begin errors++; $display("FAIL rstmid_state: got %0d cmd %h want %0d 0000", state_dbg, bus.spi_cmd, IDLE); end
        @(negedge clk);
        checks++; if ((bus.req_done | bus.req_err) !== 3'b000) begin errors++; $display("FAIL rstmid_no_pulse: got %b/%b want 000/000", bus.req_done, bus.req_err); end
        rst_n = 1'b1;
        wait_wrt(4, cyc, ok);
        checks++; if (!ok || bus.grant !== 3'b001 || bus.spi_cmd !== 16'h4444) begin errors++; $display("FAIL rstmid_regrant: got %b %h want 001 4444 (ok=%0b)", bus.grant, bus.spi_cmd, ok); end
        wait_resp(80, cyc, ok);
        checks++; if (!ok || bus.req_done !== 3'b001) begin errors++; $display("FAIL rstmid_done: got %b want 001 (ok=%0b)", bus.req_done, ok); end
        checks++; if (bus.rd_data !== 16'h1E1E) begin errors++; $display("FAIL rstmid_rd: got %h want 1e1e", bus.rd_data); end
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus.req     = '0;
        bus.req_cmd = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_stale_done();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
